// File: rtl/smpl_queue.sv
// Circular stereo sample store that, once TAPS samples are held, streams the most recent TAPS
// samples (oldest first) to downstream FIR stages after every accepted write.
module smpl_queue #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned TAPS  = 1021
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wrt_smpl,
  input  logic signed [15:0] lft_smpl,
  input  logic signed [15:0] rght_smpl,
  output logic               sequencing,
  output logic signed [15:0] lft_out,
  output logic signed [15:0] rght_out,
  output logic               overrun
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(TAPS + 1);
  localparam logic [PtrW-1:0] TapsP = PtrW'(TAPS);
  localparam logic [CntW-1:0] TapsC = CntW'(TAPS);

  typedef enum logic {StIdle, StRead} state_e;

  state_e          state_q, state_d;
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q, rd_base;
  logic [CntW-1:0] cnt_q, cnt_nxt, rd_cnt_q;
  logic            seq_q, ovr_q;
  logic [15:0]     lft_q, rght_q;
  logic [31:0]     mem [DEPTH];
  logic [31:0]     rd_data;

  logic accept, drop, trigger, rd_emit;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (trigger) state_d = StRead;
      StRead: if (rd_cnt_q == TapsC) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output / control decode. READ spans the gap cycle, the TAPS burst cycles and nothing more.
  always_comb begin
    accept  = 1'b0;
    drop    = 1'b0;
    rd_emit = 1'b0;
    cnt_nxt = (cnt_q == TapsC) ? cnt_q : cnt_q + CntW'(1);
    unique case (state_q)
      StIdle: accept = wrt_smpl;
      StRead: begin
        drop    = wrt_smpl;
        rd_emit = (rd_cnt_q != TapsC);
      end
      default: ;
    endcase
    trigger = accept && (cnt_nxt == TapsC);
    rd_base = wr_ptr_q + PtrW'(1) - TapsP;
  end

  assign rd_data = mem[rd_ptr_q];

  // Storage has no reset; a write coinciding with rst is discarded.
  always_ff @(posedge clk) begin
    if (accept && !rst) begin
      mem[wr_ptr_q] <= {lft_smpl, rght_smpl};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      rd_ptr_q <= '0;
      rd_cnt_q <= '0;
      seq_q    <= 1'b0;
      lft_q    <= '0;
      rght_q   <= '0;
      ovr_q    <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
        cnt_q    <= cnt_nxt;
      end
      if (trigger) begin
        rd_ptr_q <= rd_base;
        rd_cnt_q <= '0;
      end else if (rd_emit) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
        rd_cnt_q <= rd_cnt_q + CntW'(1);
      end
      seq_q  <= rd_emit;
      // Downstream accumulators integrate every cycle, so idle outputs must be zero.
      lft_q  <= rd_emit ? rd_data[31:16] : 16'h0000;
      rght_q <= rd_emit ? rd_data[15:0]  : 16'h0000;
      if (drop) begin
        ovr_q <= 1'b1;
      end
    end
  end

  assign sequencing = seq_q;
  assign lft_out    = lft_q;
  assign rght_out   = rght_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_smpl_queue.sv
// Scoreboard bench for smpl_queue (DEPTH=8, TAPS=5): directed fill/wrap/overrun/reset then random.
module tb_smpl_queue;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned TAPS  = 5;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               wrt_smpl = 1'b0;
  logic signed [15:0] lft_smpl = '0;
  logic signed [15:0] rght_smpl = '0;
  logic               sequencing;
  logic signed [15:0] lft_out;
  logic signed [15:0] rght_out;
  logic               overrun;

  smpl_queue #(.DEPTH(DEPTH), .TAPS(TAPS)) dut (
    .clk        (clk),
    .rst        (rst),
    .wrt_smpl   (wrt_smpl),
    .lft_smpl   (lft_smpl),
    .rght_smpl  (rght_smpl),
    .sequencing (sequencing),
    .lft_out    (lft_out),
    .rght_out   (rght_out),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] hist[$];
  int          m_cnt = 0;
  int          busy_end = -1;
  bit          ovr_exp = 1'b0;
  int          cyc = 0;
  bit          mon_en = 1'b0;
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic chk(input string nm, input bit ok, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Reference: the last TAPS accepted samples; every accepted write that leaves TAPS of them
  // held schedules a burst in cycles c+2..c+TAPS+1, and writes up to that end are dropped.
  task automatic m_step(input int c, input bit w, input logic [15:0] l, input logic [15:0] r,
                        input bit rs);
    if (rs) begin
      hist.delete();
      m_cnt    = 0;
      busy_end = -1;
      ovr_exp  = 1'b0;
      while (sb.size() > 0 && sb[$].cyc > c) void'(sb.pop_back());
    end else if (w) begin
      if (c <= busy_end) begin
        ovr_exp = 1'b1;
      end else begin
        hist.push_back({l, r});
        if (hist.size() > TAPS) void'(hist.pop_front());
        if (m_cnt < TAPS) m_cnt++;
        if (m_cnt == TAPS) begin
          for (int k = 0; k < TAPS; k++) sb.push_back('{cyc: c + 2 + k, data: hist[k]});
          busy_end = c + TAPS + 1;
        end
      end
    end
  endtask

  task automatic step(input bit w, input logic [15:0] l, input logic [15:0] r, input bit rs);
    wrt_smpl  = w;
    lft_smpl  = l;
    rght_smpl = r;
    rst       = rs;
    @(posedge clk);
    m_step(cyc, w, l, r, rs);
    cyc++;
    #1;
    wrt_smpl = 1'b0;
    rst      = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 16'h0, 1'b0);
  endtask

  task automatic wr(input int v);
    step(1'b1, 16'(v), 16'(-v), 1'b0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a burst sample.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sequencing === 1'b1) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
          chk("burst_missing", 1'b0, 32'(cyc), 32'(sb[0].cyc));
          void'(sb.pop_front());
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
          chk("burst_data", {lft_out, rght_out} === sb[0].data, {lft_out, rght_out}, sb[0].data);
          void'(sb.pop_front());
        end else begin
          chk("spurious_sequencing", 1'b0, 32'(sequencing), 32'h0);
        end
      end else begin
        chk("idle_outputs_zero", {sequencing, lft_out, rght_out} === 33'h0,
            {lft_out, rght_out}, 32'h0);
        if (sb.size() > 0 && sb[0].cyc <= cyc) begin
          chk("burst_missing", 1'b0, 32'(sequencing), 32'h1);
          void'(sb.pop_front());
        end
      end
      chk("overrun", overrun === ovr_exp, 32'(overrun), 32'(ovr_exp));
    end
  end

  initial begin
    step(1'b0, 16'h0, 16'h0, 1'b1);
    mon_en = 1'b1;
    step(1'b0, 16'h0, 16'h0, 1'b1);
    // Fill then first burst
    for (int i = 1; i <= 4; i++) begin
      wr(i);
      idle(1);
    end
    wr(5);
    idle(8);
    // Wrap across the memory boundary, one write per burst completion
    for (int i = 6; i <= 12; i++) begin
      wr(i);
      idle(7);
    end
    // Write dropped in the middle of a burst
    wr(13);
    idle(2);
    wr(99);
    idle(4);
    wr(14);
    idle(8);
    // Reset in the middle of a burst, then refill
    wr(15);
    idle(3);
    step(1'b0, 16'h0, 16'h0, 1'b1);
    for (int i = 16; i <= 19; i++) begin
      wr(i);
      idle(2);
    end
    idle(8);
    wr(20);
    idle(8);
    // Write coinciding with reset is discarded
    step(1'b1, 16'h7777, 16'h8888, 1'b1);
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) == 0, 16'($urandom), 16'($urandom),
           $urandom_range(0, 299) == 0);
    end
    idle(TAPS + 4);
    chk("scoreboard_drained", sb.size() == 0, 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
